// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the AXI-Stream round-robin packet arbiter.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int PKT_COUNT_W = 16;

endpackage : axis_arb_pkg

// File: rtl/axis_rr_pick.sv
// Combinational round-robin selector: finds the first asserted request
// searching upward from the port after last_grant_i, wrapping around.
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]         req_i,
    input  logic [$clog2(NUM_PORTS)-1:0] last_grant_i,
    output logic                         found_o,
    output logic [$clog2(NUM_PORTS)-1:0] idx_o
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset down to the nearest so the nearest hit wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant_i) + k) % NUM_PORTS);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule : axis_rr_pick

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter merging NUM_PORTS AXI-Stream slaves onto
// one master; a granted packet holds the output until its tlast beat transfers.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [NUM_PORTS-1:0]            s_tvalid,
    output logic [NUM_PORTS-1:0]            s_tready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS-1:0]            s_tlast,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic                            m_tlast,
    output logic [$clog2(NUM_PORTS)-1:0]    grant_idx,
    output logic                            busy,
    output logic [PKT_COUNT_W-1:0]          pkt_count
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    arb_state_e             state_q;
    logic [IDX_W-1:0]       grant_q;
    logic [IDX_W-1:0]       last_grant_q;
    logic [PKT_COUNT_W-1:0] pkt_cnt_q;
    logic [PKT_COUNT_W-1:0] pkt_cnt_d;

    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic                   locked;
    logic                   sel_valid;
    logic                   sel_last;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   beat_done;

    axis_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .req_i        (s_tvalid),
        .last_grant_i (last_grant_q),
        .found_o      (pick_found),
        .idx_o        (pick_idx)
    );

    assign locked = (state_q == LOCK);

    // Only the granted port reaches the master side, and only while locked.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        s_tready  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (IDX_W'(i) == grant_q) begin
                sel_valid   = s_tvalid[i];
                sel_last    = s_tlast[i];
                sel_data    = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                s_tready[i] = locked & m_tready;
            end
        end
    end

    assign m_tvalid  = locked & sel_valid;
    assign m_tlast   = locked & sel_last;
    assign m_tdata   = locked ? sel_data : '0;
    assign beat_done = m_tvalid & m_tready & m_tlast;
    assign pkt_cnt_d = pkt_cnt_q + PKT_COUNT_W'(1);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
            pkt_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        state_q <= LOCK;
                    end
                end
                LOCK: begin
                    // Release only on the tlast beat; a stalled or idle granted port keeps the lock.
                    if (beat_done) begin
                        last_grant_q <= grant_q;
                        pkt_cnt_q    <= pkt_cnt_d;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = locked;
    assign grant_idx = grant_q;
    assign pkt_count = pkt_cnt_q;

endmodule : axis_rr_arbiter

// File: tb/tb_axis_rr_arbiter.sv
// Directed plus randomized bench for axis_rr_arbiter against a packet-level
// behavioural model of the round-robin rules.
module tb_axis_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic [N-1:0]  s_tvalid;
    logic [N-1:0]  s_tready;
    logic [N*W-1:0] s_tdata;
    logic [N-1:0]  s_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [W-1:0]  m_tdata;
    logic          m_tlast;
    logic [IW-1:0] grant_idx;
    logic          busy;
    logic [15:0]   pkt_count;

    int checks = 0;
    int errors = 0;

    // Model: which port owns the output (-1 = none), last winner, grant register, packet count.
    int m_lock, m_last, m_grant, m_cnt;
    int glog[$];

    // Per-port packet generator state.
    int         len  [N];
    int         left [N];
    int         beat [N];
    logic       hold [N];
    logic [W-1:0] dat [N];

    axis_rr_arbiter #(
        .NUM_PORTS  (N),
        .DATA_WIDTH (W)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
        .s_tlast   (s_tlast),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast),
        .grant_idx (grant_idx),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lock  = -1;
        m_last  = N - 1;
        m_grant = 0;
        m_cnt   = 0;
    endtask

    task automatic clear_gen();
        for (int i = 0; i < N; i++) begin
            len[i]  = 1;
            left[i] = 0;
            beat[i] = 0;
            hold[i] = 1'b0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i]        = (left[i] > 0) && !hold[i];
            s_tlast[i]         = (left[i] > 0) && (beat[i] == len[i] - 1);
            s_tdata[i*W +: W]  = dat[i];
        end
    endtask

    task automatic check_out();
        logic         ev, el;
        logic [W-1:0] ed;
        logic [N-1:0] er;
        ev = 1'b0; el = 1'b0; ed = '0; er = '0;
        if (m_lock >= 0) begin
            ev = s_tvalid[m_lock];
            el = s_tlast[m_lock];
            ed = s_tdata[m_lock*W +: W];
            if (m_tready) er[m_lock] = 1'b1;
        end
        chk("m_tvalid",  64'(m_tvalid),  64'(ev));
        chk("m_tlast",   64'(m_tlast),   64'(el));
        chk("m_tdata",   64'(m_tdata),   64'(ed));
        chk("s_tready",  64'(s_tready),  64'(er));
        chk("busy",      64'(busy),      64'(m_lock >= 0));
        chk("grant_idx", 64'(grant_idx), 64'(m_grant));
        chk("pkt_count", 64'(pkt_count), 64'(m_cnt));
    endtask

    // Advance the model by one rising edge using the inputs that were applied.
    task automatic update();
        int p;
        int found;
        if (!ARESETN) begin
            model_reset();
            return;
        end
        if (m_lock < 0) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                p = (m_last + k) % N;
                if (found == 0 && s_tvalid[p]) begin
                    found   = 1;
                    m_lock  = p;
                    m_grant = p;
                    glog.push_back(p);
                end
            end
        end else if (s_tvalid[m_lock] && m_tready) begin
            p = m_lock;
            beat[p]++;
            dat[p] = $urandom;
            if (s_tlast[p]) begin
                beat[p] = 0;
                left[p]--;
                m_last  = p;
                m_cnt   = (m_cnt + 1) % 65536;
                m_lock  = -1;
            end
        end
    endtask

    task automatic run_cycle();
        drive();
        #1;
        check_out();
        @(posedge ACLK);
        update();
        @(negedge ACLK);
    endtask

    task automatic run_until_idle(input string tag, input int budget, output int cyc);
        int done;
        cyc  = 0;
        done = 0;
        while (done == 0 && cyc < budget) begin
            run_cycle();
            cyc++;
            done = (m_lock < 0) ? 1 : 0;
            for (int i = 0; i < N; i++)
                if (left[i] > 0) done = 0;
        end
        chk(tag, 64'(done), 64'(1));
    endtask

    task automatic do_reset(input int cycles);
        ARESETN = 1'b0;
        model_reset();
        #1;
        check_out();
        for (int c = 0; c < cycles; c++) run_cycle();
        clear_gen();
        ARESETN = 1'b1;
    endtask

    initial begin
        int cyc;
        int exp_seq[5] = '{0, 1, 2, 3, 0};

        for (int i = 0; i < N; i++) dat[i] = $urandom;
        clear_gen();
        m_tready = 1'b0;
        ARESETN  = 1'b0;
        drive();
        model_reset();

        // Reset state
        @(negedge ACLK);
        #1;
        check_out();
        @(negedge ACLK);
        run_cycle();
        run_cycle();
        ARESETN = 1'b1;
        run_cycle();

        // Single 3-beat packet on port 0
        glog.delete();
        len[0] = 3; left[0] = 1; m_tready = 1'b1;
        run_until_idle("t1_drain", 20, cyc);
        chk("t1_cycles", 64'(cyc), 64'(4));
        chk("t1_ngrants", 64'(glog.size()), 64'(1));
        if (glog.size() > 0) chk("t1_grant", 64'(glog[0]), 64'(0));
        chk("t1_cnt", 64'(pkt_count), 64'(1));
        chk("t1_busy", 64'(busy), 64'(0));

        // All ports requesting 2-beat packets back to back
        do_reset(2);
        glog.delete();
        for (int i = 0; i < N; i++) begin len[i] = 2; left[i] = 1; end
        left[0] = 2;
        run_until_idle("t2_drain", 60, cyc);
        chk("t2_cycles", 64'(cyc), 64'(15));
        chk("t2_ngrants", 64'(glog.size()), 64'(5));
        for (int k = 0; k < 5 && k < glog.size(); k++)
            chk("t2_order", 64'(glog[k]), 64'(exp_seq[k]));
        chk("t2_cnt", 64'(pkt_count), 64'(5));

        // Port 0 arrives while port 1 is locked; ready toggles
        glog.delete();
        len[1] = 4; left[1] = 1;
        for (int c = 0; c < 12; c++) begin
            m_tready = (c % 2 == 0);
            if (c == 2) begin len[0] = 2; left[0] = 1; end
            run_cycle();
        end
        m_tready = 1'b1;
        run_until_idle("t3_drain", 30, cyc);
        chk("t3_ngrants", 64'(glog.size()), 64'(2));
        if (glog.size() >= 2) begin
            chk("t3_first", 64'(glog[0]), 64'(1));
            chk("t3_second", 64'(glog[1]), 64'(0));
        end

        // Port 2 drops valid for three cycles mid-packet
        glog.delete();
        len[2] = 6; left[2] = 1;
        for (int c = 0; c < 10 && beat[2] < 2; c++) run_cycle();
        chk("t4_midpkt", 64'(beat[2]), 64'(2));
        hold[2] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive();
            #1;
            check_out();
            chk("t4_busy", 64'(busy), 64'(1));
            chk("t4_mvalid", 64'(m_tvalid), 64'(0));
            chk("t4_grant", 64'(grant_idx), 64'(2));
            @(posedge ACLK);
            update();
            @(negedge ACLK);
        end
        hold[2] = 1'b0;
        run_until_idle("t4_drain", 30, cyc);
        chk("t4_ngrants", 64'(glog.size()), 64'(1));

        // Reset during beat 2 of a port 3 packet
        len[3] = 4; left[3] = 1;
        for (int c = 0; c < 10 && beat[3] < 1; c++) run_cycle();
        chk("t5_midpkt", 64'(beat[3]), 64'(1));
        drive();
        ARESETN = 1'b0;
        model_reset();
        #1;
        check_out();
        chk("t5_rdy", 64'(s_tready), 64'(0));
        chk("t5_mvalid", 64'(m_tvalid), 64'(0));
        chk("t5_cnt", 64'(pkt_count), 64'(0));
        @(negedge ACLK);
        run_cycle();
        clear_gen();
        ARESETN = 1'b1;
        run_cycle();
        glog.delete();
        left[0] = 1; left[3] = 1;
        run_until_idle("t5_drain", 20, cyc);
        chk("t5_ngrants", 64'(glog.size()), 64'(2));
        if (glog.size() >= 2) begin
            chk("t5_first", 64'(glog[0]), 64'(0));
            chk("t5_second", 64'(glog[1]), 64'(3));
        end

        // Randomized traffic, lengths, stalls and valid drops
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (left[i] == 0 && $urandom_range(0, 3) == 0) begin
                    len[i]  = $urandom_range(1, 4);
                    left[i] = 1;
                end
                hold[i] = ($urandom_range(0, 7) == 0);
            end
            m_tready = ($urandom_range(0, 3) != 0);
            run_cycle();
        end
        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        m_tready = 1'b1;
        run_until_idle("t6_drain", 200, cyc);

        // Packet counter wrap
        force dut.pkt_cnt_q = 16'hFFFF;
        #1;
        release dut.pkt_cnt_q;
        m_cnt = 65535;
        run_cycle();
        chk("t7_preload", 64'(pkt_count), 64'(16'hFFFF));
        len[1] = 1; left[1] = 1;
        run_until_idle("t7_drain", 10, cyc);
        chk("t7_wrap", 64'(pkt_count), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_axis_rr_arbiter
